phase_timer_datapath: RTL and testbench

//   Parametrised intersection datapath: N signal phases, per-phase programmable green time,

---
 rtl/phase_timer_datapath.sv | 155 +++++++++++++++
 tb/tb_phase_timer_datapath.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer_datapath.sv
// Intersection timing datapath: tick prescaler, phase time registers, loadable down counter,
// registered lamp drivers and a sticky conflict guard that forces all-red once two phases go live.
module phase_timer_datapath #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TICK_HZ        = 1,
  parameter int NUM_PHASES     = 2,
  parameter int TIME_W         = 8,
  parameter int GREEN_DEFAULT  = 30,
  parameter int YELLOW_DEFAULT = 5,
  parameter int ALLRED_DEFAULT = 2,
  localparam int PH_W          = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_enable,
  input  logic [1:0]              time_sel,
  input  logic [PH_W-1:0]         phase_sel,
  input  logic                    pause,
  input  logic [2*NUM_PHASES-1:0] light_cmd,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [TIME_W-1:0]       cfg_data,
  output logic                    timer_zero,
  output logic [TIME_W-1:0]       count,
  output logic                    tick,
  output logic [NUM_PHASES-1:0]   red,
  output logic [NUM_PHASES-1:0]   yellow,
  output logic [NUM_PHASES-1:0]   green,
  output logic                    fault
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int DIV_W    = $clog2(TICK_DIV);

  logic [DIV_W-1:0]      r_presc;
  logic [TIME_W-1:0]     r_green [NUM_PHASES];
  logic [TIME_W-1:0]     r_yellow;
  logic [TIME_W-1:0]     r_allred;
  logic [TIME_W-1:0]     r_count;
  logic                  r_blink;
  logic                  r_fault;
  logic [NUM_PHASES-1:0] r_red;
  logic [NUM_PHASES-1:0] r_yel;
  logic [NUM_PHASES-1:0] r_grn;

  logic                  w_tick;
  logic [TIME_W-1:0]     w_wdata;
  logic [TIME_W-1:0]     w_green_sel;
  logic [TIME_W-1:0]     w_load_val;
  logic [2:0]            w_active;
  logic                  w_conflict;
  logic [NUM_PHASES-1:0] w_red;
  logic [NUM_PHASES-1:0] w_yel;
  logic [NUM_PHASES-1:0] w_grn;

  assign w_tick     = (r_presc == DIV_W'(TICK_DIV - 1));
  assign tick       = w_tick;
  assign count      = r_count;
  assign timer_zero = (r_count == '0);
  assign fault      = r_fault;
  assign red        = r_red;
  assign yellow     = r_yel;
  assign green      = r_grn;

  // A zero time would make a phase vanish, so it is stored as the minimum of 1.
  assign w_wdata = (cfg_data == '0) ? TIME_W'(1) : cfg_data;

  always_comb begin
    w_green_sel = r_green[0];
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (phase_sel == PH_W'(p)) w_green_sel = r_green[p];
    end
    case (time_sel)
      2'd0:    w_load_val = w_green_sel;
      2'd1:    w_load_val = r_yellow;
      2'd2:    w_load_val = r_allred;
      default: w_load_val = TIME_W'(1);
    endcase
  end

  always_comb begin
    w_active = '0;
    w_red    = '0;
    w_yel    = '0;
    w_grn    = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (light_cmd[2*p +: 2] == 2'b01 || light_cmd[2*p +: 2] == 2'b10) w_active = w_active + 3'd1;
      case (light_cmd[2*p +: 2])
        2'b00:   w_red[p] = 1'b1;
        2'b01:   w_yel[p] = 1'b1;
        2'b10:   w_grn[p] = 1'b1;
        default: w_yel[p] = r_blink;
      endcase
    end
    w_conflict = (w_active > 3'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_blink <= 1'b0;
    end else begin
      // Restarting on load gives the first decrement a full tick period.
      if (load_enable || w_tick) r_presc <= '0;
      else                       r_presc <= r_presc + 1'b1;
      if (w_tick) r_blink <= ~r_blink;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PHASES; p++) r_green[p] <= TIME_W'(GREEN_DEFAULT);
      r_yellow <= TIME_W'(YELLOW_DEFAULT);
      r_allred <= TIME_W'(ALLRED_DEFAULT);
    end else if (cfg_we) begin
      for (int p = 0; p < NUM_PHASES; p++) begin
        if (cfg_addr == 3'(p)) r_green[p] <= w_wdata;
      end
      if (cfg_addr == 3'(NUM_PHASES))     r_yellow <= w_wdata;
      if (cfg_addr == 3'(NUM_PHASES + 1)) r_allred <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load_enable) begin
      r_count <= w_load_val;
    end else if (w_tick && !pause && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  // The conflicting cycle itself already drives all-red, not just the cycles after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
      r_red   <= '1;
      r_yel   <= '0;
      r_grn   <= '0;
    end else begin
      r_fault <= r_fault | w_conflict;
      if (w_conflict || r_fault) begin
        r_red <= '1;
        r_yel <= '0;
        r_grn <= '0;
      end else begin
        r_red <= w_red;
        r_yel <= w_yel;
        r_grn <= w_grn;
      end
    end
  end

endmodule

// File: tb/tb_phase_timer_datapath.sv
// Directed bench for phase_timer_datapath with an abstract cycle-count model checked every cycle.
module tb_phase_timer_datapath;
  localparam int TDIV = 4;
  localparam int NP   = 2;
  localparam int TW   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_enable = 1'b0;
  logic [1:0]    time_sel = '0;
  logic [0:0]    phase_sel = '0;
  logic          pause = 1'b0;
  logic [2*NP-1:0] light_cmd = '0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [TW-1:0] cfg_data = '0;
  logic          timer_zero;
  logic [TW-1:0] count;
  logic          tick;
  logic [NP-1:0] red, yellow, green;
  logic          fault;

  phase_timer_datapath #(.CLK_FREQ(4), .TICK_HZ(1), .NUM_PHASES(NP), .TIME_W(TW)) dut (
    .clk(clk), .reset(reset), .load_enable(load_enable), .time_sel(time_sel),
    .phase_sel(phase_sel), .pause(pause), .light_cmd(light_cmd), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .timer_zero(timer_zero), .count(count),
    .tick(tick), .red(red), .yellow(yellow), .green(green), .fault(fault)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: cycles since reset/last load decide the tick; times kept as plain integers.
  int m_cyc, m_count;
  int m_regs [NP+2];
  bit m_blink, m_fault;
  logic [NP-1:0] m_red, m_yel, m_grn;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc = 0; m_count = 0; m_blink = 0; m_fault = 0;
      for (int p = 0; p < NP; p++) m_regs[p] = 30;
      m_regs[NP] = 5; m_regs[NP+1] = 2;
      m_red = '1; m_yel = '0; m_grn = '0;
    end else begin
      bit tk;
      int nact, ldv;
      tk = (m_cyc % TDIV) == TDIV - 1;
      nact = 0;
      for (int p = 0; p < NP; p++)
        if (light_cmd[2*p +: 2] == 2'b01 || light_cmd[2*p +: 2] == 2'b10) nact++;
      for (int p = 0; p < NP; p++) begin
        m_red[p] = (nact > 1 || m_fault) ? 1'b1 : (light_cmd[2*p +: 2] == 2'b00);
        m_grn[p] = (nact > 1 || m_fault) ? 1'b0 : (light_cmd[2*p +: 2] == 2'b10);
        m_yel[p] = (nact > 1 || m_fault) ? 1'b0 :
                   (light_cmd[2*p +: 2] == 2'b01) ? 1'b1 :
                   (light_cmd[2*p +: 2] == 2'b11) ? m_blink : 1'b0;
      end
      case (time_sel)
        2'd0:    ldv = (int'(phase_sel) < NP) ? m_regs[phase_sel] : m_regs[0];
        2'd1:    ldv = m_regs[NP];
        2'd2:    ldv = m_regs[NP+1];
        default: ldv = 1;
      endcase
      if (load_enable) begin
        m_count = ldv;
        m_cyc = 0;
      end else begin
        if (tk && !pause && m_count > 0) m_count--;
        m_cyc++;
      end
      if (tk) m_blink = !m_blink;
      if (cfg_we && cfg_addr < NP + 2) m_regs[cfg_addr] = (cfg_data == 0) ? 1 : int'(cfg_data);
      if (nact > 1) m_fault = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("count", int'(count), m_count);
      chk("timer_zero", int'(timer_zero), int'(m_count == 0));
      chk("tick", int'(tick), int'((m_cyc % TDIV) == TDIV - 1));
      chk("red", int'(red), int'(m_red));
      chk("yellow", int'(yellow), int'(m_yel));
      chk("green", int'(green), int'(m_grn));
      chk("fault", int'(fault), int'(m_fault));
    end
  end

  task automatic load(input int ts, input int ps);
    time_sel = 2'(ts); phase_sel = 1'(ps); load_enable = 1'b1;
    @(negedge clk);
    load_enable = 1'b0;
  endtask

  task automatic cfg(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_data = TW'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    logic prev;
    int tog;
    repeat (3) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_tz", int'(timer_zero), 1);
    chk("rst_red", int'(red), 3);
    chk("rst_yellow", int'(yellow), 0);
    chk("rst_green", int'(green), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_tick", int'(tick), 0);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_tick_early", int'(tick), 0);
    @(negedge clk);
    chk("first_tick", int'(tick), 1);

    load(0, 1);
    chk("load_green1", int'(count), 30);
    repeat (119) @(negedge clk);
    chk("count_at_119", int'(count), 1);
    @(negedge clk);
    chk("count_at_120", int'(count), 0);
    chk("tz_at_120", int'(timer_zero), 1);
    repeat (8) @(negedge clk);
    chk("zero_holds", int'(count), 0);

    cfg(2, 0);
    load(1, 0);
    chk("zero_write_as_1", int'(count), 1);
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 8'd9;
    time_sel = 2'd1; load_enable = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; load_enable = 1'b0;
    chk("same_cycle_old", int'(count), 1);
    load(1, 0);
    chk("new_yellow", int'(count), 9);
    load(3, 0);
    chk("const_one", int'(count), 1);
    cfg(5, 77);
    load(2, 0);
    chk("bad_addr_ignored", int'(count), 2);

    cfg(0, 10);
    load(0, 0);
    chk("load_ten", int'(count), 10);
    pause = 1'b1;
    repeat (12) @(negedge clk);
    chk("paused", int'(count), 10);
    pause = 1'b0;
    repeat (4) @(negedge clk);
    chk("resumed", int'(count), 9);

    light_cmd = 4'b1111;
    @(negedge clk);
    chk("flash_red", int'(red), 0);
    chk("flash_green", int'(green), 0);
    prev = yellow[0];
    tog = 0;
    repeat (16) begin
      @(negedge clk);
      if (yellow[0] != prev) tog++;
      prev = yellow[0];
    end
    chk("blink_toggles", tog, 4);
    chk("flash_no_fault", int'(fault), 0);

    light_cmd = 4'b0010;
    @(negedge clk);
    chk("legal_red", int'(red), 2);
    chk("legal_green", int'(green), 1);
    light_cmd = 4'b0110;
    @(negedge clk);
    chk("conflict_fault", int'(fault), 1);
    chk("conflict_red", int'(red), 3);
    chk("conflict_green", int'(green), 0);
    light_cmd = 4'b0010;
    repeat (3) @(negedge clk);
    chk("sticky_fault", int'(fault), 1);
    chk("sticky_red", int'(red), 3);

    chk_en = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("reclear_fault", int'(fault), 0);
    chk("reclear_red", int'(red), 3);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_green", int'(green), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
